hs_bus_arbiter: RTL and testbench
=================================

# hs_bus_arbiter

Shares the single handshake port into the interconnect between N requesters, e.g. the SPI boot controller, the CPU data port and a debug master. It does round-robin arbitration per transaction. A lock input lets a requester keep the bus across a multi-access sequence, such as an SPI inhibit/fill/release/read run. A watchdog returns an error completion if the bus never answers.

## Interface
- N_REQ, 2: number of requesters (2..8).
- TIMEOUT, 1023: maximum cycles a granted transaction waits for `bus_hs_ready_i`. 0 disables the watchdog.
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset is asynchronous and active-high.
- req_rd_i  in  N_REQ  per-requester read strobe, held until its ready.
- req_wr_i  in  N_REQ  per-requester write strobe, held until its ready.
- req_addr_i  in  32*N_REQ  address; requester k occupies bits [32k+31:32k].
- req_wdata_i  in  32*N_REQ  write data, same packing.
- req_lock_i  in  N_REQ  keep grant after current transaction completes.
- req_ready_o  out  N_REQ  one-cycle completion pulse to the granted requester only.
- req_rdata_o  out  32  read data, valid while any `req_ready_o` bit is high.
- req_err_o  out  1  pulses with `req_ready_o` on watchdog completion.
- grant_o  out  N_REQ  one-hot current owner; 0 when idle.
- bus_hs_rd_o  out  1  read strobe to interconnect.
- bus_hs_wr_o  out  1  write strobe to interconnect.
- bus_hs_addr_o  out  32  address to interconnect.
- bus_hs_data_o  out  32  write data to interconnect.
- bus_hs_ready_i  in  1  interconnect completion pulse.
- bus_hs_data_i  in  32  interconnect read data, valid with ready.

## Operation
- **Requests.** Requester k is requesting when `req_rd_i[k] | req_wr_i[k]`. Asserting rd and wr together is illegal; rd wins when forwarded.
- **FSM states:** IDLE, BUSY, HOLD.
- **IDLE:**
  - Bus outputs are 0 and `grant_o` is 0.
  - If any request is pending, the winner is the first requesting index after `last_r`, searching upward modulo N_REQ.
  - Register `grant_r`, go to BUSY and clear the watchdog counter.
- **BUSY:**
  - `bus_hs_*_o` are a combinational mux of the granted requester's rd/wr/addr/wdata.
  - `grant_o = grant_r`.
  - The watchdog counter increments each cycle.
- **BUSY exit on `bus_hs_ready_i = 1`:**
  - `req_ready_o[g] = 1` and `req_rdata_o = bus_hs_data_i`.
  - `last_r <= g`.
  - Next state is HOLD if `req_lock_i[g]`, else IDLE.
- **BUSY exit on watchdog:** when the counter reaches TIMEOUT-1 without ready (TIMEOUT ≠ 0):
  - Bus strobes are forced to 0 in that cycle.
  - `req_ready_o[g] = 1`, `req_rdata_o = 32'hDEADBEEF`, `req_err_o = 1`.
  - Same next-state rule as a ready exit.
- **BUSY abandon:** if the granted requester drops both strobes before ready, the transaction is abandoned.
  - No `req_ready_o` pulse.
  - Next state is IDLE, with `last_r <= g`.
  - A `bus_hs_ready_i` arriving in that same cycle is ignored.
- **HOLD:**
  - Bus strobes are 0 and `grant_o = grant_r`.
  - A request from g goes to BUSY (counter cleared).
  - If `req_lock_i[g]` is low and g has no request, go to IDLE.
  - Requests from other requesters are ignored.
- **Round-robin pointer.** `last_r` updates only when the grant is released. A locked sequence therefore counts as one turn.
- **Read data** is a registered-free pass-through, 0 when no ready pulse.
- **Simultaneous events:**
  - Ready and watchdog in the same cycle: ready wins, `req_err_o = 0`.
  - Lock asserted in the same cycle as ready: takes effect (goes to HOLD).

## Timing
- **Reset (async assert, sync release):**
  - State IDLE, `grant_r = 0`, `last_r = N_REQ-1` (requester 0 has first priority), counter 0.
  - All outputs 0.
- **Latency:**
  - Request to bus strobe: 1 cycle (IDLE decision cycle, then BUSY).
  - Bus ready to `req_ready_o`: 0 cycles (combinational).
  - Back-to-back transactions by different requesters: 1 idle cycle between them.
  - Locked requester in HOLD: request to bus strobe is 1 cycle.
- **Reset mid-BUSY:** all strobes drop immediately and no ready pulse is produced. The interconnect must tolerate the abort.
- **Counter:** width `$clog2(TIMEOUT+1)`; no wrap, since it stops at the timeout exit.

## Test plan
- **Single read.** Reset, then `req_rd_i = 2'b01`, addr 0x60014. Required: bus rd high 1 cycle later with addr 0x60014. Slave returns ready with data 8 after 3 cycles. Required: `req_ready_o = 01` that cycle, `req_rdata_o = 8`, IDLE next.
- **Contention fairness.** Both requesters hold reads continuously, slave ready after 2 cycles. Required: grants alternate 0,1,0,1, with exactly 1 idle cycle between transactions.
- **Lock sequence.**
  - Requester 0 sets lock and issues 9 writes to 0x60008 while requester 1 requests throughout.
  - Required: requester 1 gets no grant until requester 0 drops lock in HOLD.
  - Requester 1 is then granted 2 cycles after lock drops.
- **Watchdog.** TIMEOUT = 16, slave never answers. Required: `req_ready_o[0]` and `req_err_o` pulse exactly 16 cycles after the bus strobe asserts, `req_rdata_o = 0xDEADBEEF`.
- **Abandon and async reset.**
  - Requester 1 drops rd mid-BUSY. Required: no ready pulse, and requester 0 (pending) is granted next.
  - Assert `rst_i` mid-BUSY. Required: bus strobes and `grant_o` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hs_bus_arbiter.sv
// Round-robin arbiter sharing one handshake bus port between N_REQ requesters,
// with per-requester bus lock and a watchdog that completes stalled transfers with an error.
module hs_bus_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_rd_i,
    input  logic [N_REQ-1:0]     req_wr_i,
    input  logic [32*N_REQ-1:0]  req_addr_i,
    input  logic [32*N_REQ-1:0]  req_wdata_i,
    input  logic [N_REQ-1:0]     req_lock_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [31:0]          req_rdata_o,
    output logic                 req_err_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 bus_hs_rd_o,
    output logic                 bus_hs_wr_o,
    output logic [31:0]          bus_hs_addr_o,
    output logic [31:0]          bus_hs_data_o,
    input  logic                 bus_hs_ready_i,
    input  logic [31:0]          bus_hs_data_i
);

    localparam int LW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [31:0]   ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state_reg;
    logic [N_REQ-1:0]   grant_reg;
    logic [LW-1:0]      gidx_reg;
    logic [LW-1:0]      last_reg;
    logic [CW-1:0]      cnt_reg;

    logic [N_REQ-1:0]   req_vec;
    logic [31:0]        addr_arr  [N_REQ];
    logic [31:0]        wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_vec[gi]   = req_rd_i[gi] | req_wr_i[gi];
            assign addr_arr[gi]  = req_addr_i[32*gi +: 32];
            assign wdata_arr[gi] = req_wdata_i[32*gi +: 32];
        end
    endgenerate

    logic g_rd, g_wr, g_req, g_lock;
    logic busy, timeout_hit, ready_exit, wd_exit, abandon, done;

    assign g_rd   = req_rd_i[gidx_reg];
    assign g_wr   = req_wr_i[gidx_reg];
    assign g_req  = g_rd | g_wr;
    assign g_lock = req_lock_i[gidx_reg];

    assign busy        = (state_reg == BUSY);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
    // A dropped request takes precedence over a late ready: the owner is no longer listening.
    assign abandon     = busy && !g_req;
    assign ready_exit  = busy && g_req && bus_hs_ready_i;
    assign wd_exit     = busy && g_req && !bus_hs_ready_i && timeout_hit;
    assign done        = ready_exit | wd_exit;

    assign bus_hs_rd_o   = busy && g_rd && !wd_exit;
    assign bus_hs_wr_o   = busy && g_wr && !g_rd && !wd_exit;
    assign bus_hs_addr_o = busy ? addr_arr[gidx_reg]  : '0;
    assign bus_hs_data_o = busy ? wdata_arr[gidx_reg] : '0;

    assign grant_o     = grant_reg;
    assign req_ready_o = done ? grant_reg : '0;
    assign req_err_o   = wd_exit;
    assign req_rdata_o = ready_exit ? bus_hs_data_i : (wd_exit ? ERR_DATA : '0);

    // Round-robin winner: first requester strictly after last_reg, wrapping.
    logic          win_found;
    logic [LW-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_vec[(int'(last_reg) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = LW'((int'(last_reg) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            last_reg  <= LW'(N_REQ - 1);
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg <= BUSY;
                        grant_reg <= ONE_HOT0 << win_idx;
                        gidx_reg  <= win_idx;
                        cnt_reg   <= '0;
                    end
                end
                BUSY: begin
                    if (abandon) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        last_reg  <= gidx_reg;
                    end else if (done) begin
                        last_reg <= gidx_reg;
                        if (g_lock) begin
                            state_reg <= HOLD;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= '0;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                HOLD: begin
                    if (g_req) begin
                        state_reg <= BUSY;
                        cnt_reg   <= '0;
                    end else if (!g_lock) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        last_reg  <= gidx_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_bus_arbiter.sv
// Directed bench for hs_bus_arbiter: a per-cycle vector table for basic reads, fairness and
// write forwarding, then hand sequences for lock, watchdog, abandon and async reset.
module tb_hs_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;
    localparam logic [31:0] A0 = 32'h0006_0014;
    localparam logic [31:0] A1 = 32'h0007_0020;
    localparam logic [31:0] W1 = 32'h2222_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd, wr, lock;
    logic [63:0] addr, wdata;
    logic        bus_ready;
    logic [31:0] bus_data;

    logic [1:0]  req_ready;
    logic [31:0] req_rdata;
    logic        req_err;
    logic [1:0]  grant;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr, bus_wdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hs_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_rd_i       (rd),
        .req_wr_i       (wr),
        .req_addr_i     (addr),
        .req_wdata_i    (wdata),
        .req_lock_i     (lock),
        .req_ready_o    (req_ready),
        .req_rdata_o    (req_rdata),
        .req_err_o      (req_err),
        .grant_o        (grant),
        .bus_hs_rd_o    (bus_rd),
        .bus_hs_wr_o    (bus_wr),
        .bus_hs_addr_o  (bus_addr),
        .bus_hs_data_o  (bus_wdata),
        .bus_hs_ready_i (bus_ready),
        .bus_hs_data_i  (bus_data)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        rdy;
        logic [31:0] bd;
        logic [1:0]  g;
        logic        brd;
        logic        bwr;
        logic [31:0] ba;
        logic [1:0]  rr;
        logic [31:0] rdat;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] obs();
        return {26'd0, grant, bus_rd, bus_wr, bus_addr, req_ready, req_rdata, req_err};
    endfunction

    function automatic logic [95:0] pack(logic [1:0] g, logic r, logic w, logic [31:0] a,
                                         logic [1:0] rr, logic [31:0] d, logic e);
        return {26'd0, g, r, w, a, rr, d, e};
    endfunction

    initial begin
        // Fields: rd, wr, bus_ready, bus_data | grant, bus_rd, bus_wr, bus_addr, req_ready, rdata, err
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[1]  = '{2'b01, 2'b00, 1'b0, 32'h0,  2'b01, 1'b1, 1'b0, A0,    2'b00, 32'h0,  1'b0};
        vecs[2]  = '{2'b01, 2'b00, 1'b0, 32'h0,  2'b01, 1'b1, 1'b0, A0,    2'b00, 32'h0,  1'b0};
        vecs[3]  = '{2'b01, 2'b00, 1'b0, 32'h0,  2'b01, 1'b1, 1'b0, A0,    2'b00, 32'h0,  1'b0};
        vecs[4]  = '{2'b01, 2'b00, 1'b1, 32'h8,  2'b01, 1'b1, 1'b0, A0,    2'b01, 32'h8,  1'b0};
        vecs[5]  = '{2'b00, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[6]  = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[7]  = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b10, 1'b1, 1'b0, A1,    2'b00, 32'h0,  1'b0};
        vecs[8]  = '{2'b11, 2'b00, 1'b1, 32'hA1, 2'b10, 1'b1, 1'b0, A1,    2'b10, 32'hA1, 1'b0};
        vecs[9]  = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[10] = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b01, 1'b1, 1'b0, A0,    2'b00, 32'h0,  1'b0};
        vecs[11] = '{2'b11, 2'b00, 1'b1, 32'hA2, 2'b01, 1'b1, 1'b0, A0,    2'b01, 32'hA2, 1'b0};
        vecs[12] = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[13] = '{2'b11, 2'b00, 1'b0, 32'h0,  2'b10, 1'b1, 1'b0, A1,    2'b00, 32'h0,  1'b0};
        vecs[14] = '{2'b11, 2'b00, 1'b1, 32'hA3, 2'b10, 1'b1, 1'b0, A1,    2'b10, 32'hA3, 1'b0};
        vecs[15] = '{2'b00, 2'b00, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[16] = '{2'b00, 2'b10, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};
        vecs[17] = '{2'b00, 2'b10, 1'b0, 32'h0,  2'b10, 1'b0, 1'b1, A1,    2'b00, 32'h0,  1'b0};
        // rd and wr together: rd is forwarded
        vecs[18] = '{2'b10, 2'b10, 1'b1, 32'h5,  2'b10, 1'b1, 1'b0, A1,    2'b10, 32'h5,  1'b0};
        // Stray bus ready while idle must not reach any requester
        vecs[19] = '{2'b00, 2'b00, 1'b1, 32'h99, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0,  1'b0};

        rst = 1'b1; rd = '0; wr = '0; lock = '0;
        addr = {A1, A0}; wdata = {W1, 32'h1111_0000};
        bus_ready = 1'b0; bus_data = '0;
        #1;
        check("reset_outputs", obs(), '0);
        rd = 2'b01;
        step();
        check("reset_held", obs(), '0);
        step();
        rst = 1'b0;
        rd = '0;

        for (int i = 0; i < NV; i++) begin
            rd = vecs[i].rd; wr = vecs[i].wr;
            bus_ready = vecs[i].rdy; bus_data = vecs[i].bd;
            #1;
            check($sformatf("vec%0d", i), obs(),
                  pack(vecs[i].g, vecs[i].brd, vecs[i].bwr, vecs[i].ba,
                       vecs[i].rr, vecs[i].rdat, vecs[i].err));
            if (i == 17) check("vec17_wdata", {64'd0, bus_wdata}, {64'd0, W1});
            step();
        end
        bus_ready = 1'b0; bus_data = '0;

        // Lock: requester 0 owns the bus for 9 writes while requester 1 waits.
        addr[31:0] = 32'h0006_0008;
        lock = 2'b01; wr = 2'b01; rd = 2'b10; wdata[31:0] = 32'h100;
        #1;
        check("lock_idle", {94'd0, grant}, {94'd0, 2'b00});
        step();
        for (int k = 0; k < 9; k++) begin
            bus_ready = 1'b1;
            #1;
            check($sformatf("lock_wr%0d", k),
                  {26'd0, grant, bus_rd, bus_wr, bus_addr, bus_wdata, req_ready},
                  {26'd0, 2'b01, 1'b0, 1'b1, 32'h0006_0008, 32'h100 + 32'(k), 2'b01});
            step();
            bus_ready = 1'b0;
            if (k < 8) begin
                wr = 2'b00;
                #1;
                check("lock_hold", {90'd0, grant, bus_rd, bus_wr, req_ready}, {90'd0, 2'b01, 1'b0, 1'b0, 2'b00});
                step();
                wr = 2'b01; wdata[31:0] = 32'h100 + 32'(k + 1);
                #1;
                check("lock_hold_req", {90'd0, grant, bus_rd, bus_wr, req_ready}, {90'd0, 2'b01, 1'b0, 1'b0, 2'b00});
                step();
            end
        end
        wr = 2'b00; lock = 2'b00;
        #1;
        check("lock_drop", {94'd0, grant}, {94'd0, 2'b01});
        step();
        #1;
        check("lock_release_idle", {94'd0, grant}, {94'd0, 2'b00});
        step();
        #1;
        check("lock_grant1", {61'd0, grant, bus_rd, bus_addr}, {61'd0, 2'b10, 1'b1, A1});

        // Lock raised in the same cycle as ready keeps the grant.
        bus_ready = 1'b1; bus_data = 32'h77; lock = 2'b10; rd = 2'b11;
        #1;
        check("lock_at_ready", obs(), pack(2'b10, 1'b1, 1'b0, A1, 2'b10, 32'h77, 1'b0));
        step();
        bus_ready = 1'b0; bus_data = '0; rd = 2'b01;
        #1;
        check("hold_keep", {92'd0, grant, bus_rd, bus_wr}, {92'd0, 2'b10, 1'b0, 1'b0});
        step();
        lock = 2'b00; addr[31:0] = 32'h0006_0030;
        #1;
        check("hold_other_ignored", {92'd0, grant, bus_rd, bus_wr}, {92'd0, 2'b10, 1'b0, 1'b0});
        step();
        #1;
        check("hold_release", {94'd0, grant}, {94'd0, 2'b00});
        step();

        // Watchdog: counter is 0 in the first strobe cycle, so the 16th BUSY cycle times out.
        for (int c = 1; c <= TO; c++) begin
            #1;
            if (c < TO)
                check($sformatf("wd_wait%0d", c), {58'd0, grant, bus_rd, req_ready, req_err, req_rdata},
                      {58'd0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0});
            else
                check("wd_fire", {58'd0, grant, bus_rd, req_ready, req_err, req_rdata},
                      {58'd0, 2'b01, 1'b0, 2'b01, 1'b1, 32'hDEAD_BEEF});
            step();
        end
        #1;
        check("wd_idle", {94'd0, grant}, {94'd0, 2'b00});
        step();

        // Ready coinciding with the watchdog cycle: ready wins, no error.
        for (int c = 1; c <= TO; c++) begin
            if (c == TO) begin
                bus_ready = 1'b1; bus_data = 32'h5A5A;
                #1;
                check("wd_vs_ready", {58'd0, grant, bus_rd, req_ready, req_err, req_rdata},
                      {58'd0, 2'b01, 1'b1, 2'b01, 1'b0, 32'h5A5A});
            end
            step();
        end
        bus_ready = 1'b0; bus_data = '0;

        // Abandon: requester 1 wins, then drops rd with a simultaneous bus ready.
        rd = 2'b11;
        #1;
        check("abn_idle", {94'd0, grant}, {94'd0, 2'b00});
        step();
        #1;
        check("abn_grant1", {93'd0, grant, bus_rd}, {93'd0, 2'b10, 1'b1});
        step();
        rd = 2'b01; bus_ready = 1'b1; bus_data = 32'h1234;
        #1;
        check("abn_drop", obs(), pack(2'b10, 1'b0, 1'b0, A1, 2'b00, 32'h0, 1'b0));
        step();
        bus_ready = 1'b0; bus_data = '0;
        #1;
        check("abn_idle2", {94'd0, grant}, {94'd0, 2'b00});
        step();
        #1;
        check("abn_grant0", {61'd0, grant, bus_rd, bus_addr}, {61'd0, 2'b01, 1'b1, 32'h0006_0030});

        // Async reset mid-BUSY: outputs clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", obs(), '0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_idle", obs(), '0);
        step();
        #1;
        check("post_rst_grant0", {91'd0, grant, bus_rd, req_ready}, {91'd0, 2'b01, 1'b1, 2'b00});
        rd = '0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
